// File: rtl/race_progress_tracker.sv
// -----------------------------------------------------------------------------
// race_progress_tracker
//
// Lap/checkpoint referee for the two-player racer. It sits upstream of the
// top-level game FSM (StateEncoder) and the HUD flag renderer.
//
// The 320x240 map is split into four sectors around (CX, CY):
//   S0 x<CX,  y>=CY (start grid)    S1 x<CX,  y<CY
//   S2 x>=CX, y<CY                  S3 x>=CX, y>=CY
// A lap counts only when a player visits S0->S1->S2->S3->S0 in order.
//
// Pipeline per player:
//   stage 1: sector of the current position, registered every cycle (sec_q)
//   stage 2: progress (last correctly reached sector) and lap count
// A position change is reflected in lap/order two clock edges later.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          asynchronous reset, active low
//   state        game state: 4=RACING, 5=PAUSE, 6=FINISH, anything else
//                clears the race bookkeeping
//   p1_x, p1_y   P1 world position (10-bit unsigned)
//   p2_x, p2_y   P2 world position (10-bit unsigned)
//   p1_lap       P1 completed laps, saturates at NUM_LAPS
//   p2_lap       P2 completed laps, saturates at NUM_LAPS
//   p1_order     0=still racing, 1=first, 2=second
//   p2_order     same encoding for P2
//   is_game_end  level, high from race end until the next clear
//
// Optional build macro WRONG_WAY_EN adds:
//   p1_wrong_way, p2_wrong_way  high while the player sits in the sector
//                               just behind its last checkpoint
// -----------------------------------------------------------------------------
module race_progress_tracker #(
    parameter int unsigned NUM_LAPS       = 3,
    parameter int unsigned CX             = 160,
    parameter int unsigned CY             = 120,
    parameter logic [31:0] FINISH_TIMEOUT = 32'd1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    output logic [2:0] p1_lap,
    output logic [2:0] p2_lap,
    output logic [1:0] p1_order,
    output logic [1:0] p2_order,
    output logic       is_game_end
`ifdef WRONG_WAY_EN
    ,
    output logic       p1_wrong_way,
    output logic       p2_wrong_way
`endif
);

    typedef enum logic [1:0] {
        SEC_GRID = 2'd0,
        SEC_NW   = 2'd1,
        SEC_NE   = 2'd2,
        SEC_SE   = 2'd3
    } sector_t;

    localparam logic [2:0]  ST_RACING = 3'd4;
    localparam logic [2:0]  ST_PAUSE  = 3'd5;
    localparam logic [2:0]  ST_FINISH = 3'd6;
    localparam logic [2:0]  LAPS      = 3'(NUM_LAPS);
    localparam logic [9:0]  CX_W      = 10'(CX);
    localparam logic [9:0]  CY_W      = 10'(CY);
    localparam logic [31:0] LAST_TICK = FINISH_TIMEOUT - 32'd1;

    function automatic sector_t sector_of(input logic [9:0] x, input logic [9:0] y);
        logic east;
        logic north;
        sector_t s;
        east  = (x >= CX_W);
        north = (y < CY_W);
        case ({east, north})
            2'b00:   s = SEC_GRID;
            2'b01:   s = SEC_NW;
            2'b11:   s = SEC_NE;
            default: s = SEC_SE;
        endcase
        return s;
    endfunction

    logic racing;
    logic clear;
    assign racing = (state == ST_RACING);
    // Only RACING/PAUSE/FINISH keep race bookkeeping alive.
    assign clear  = !(racing || (state == ST_PAUSE) || (state == ST_FINISH));

    // Index 0 is P1, index 1 is P2.
    logic [1:0][9:0] pos_x;
    logic [1:0][9:0] pos_y;
    assign pos_x = {p2_x, p1_x};
    assign pos_y = {p2_y, p1_y};

    logic [1:0]      fin_now;
    logic [1:0][2:0] lap_all;
    logic [1:0][1:0] order_reg;
    logic [1:0][1:0] order_next;
    logic            first_reg;
    logic            first_next;
    logic            end_reg;
    logic            end_next;
    logic [31:0]     cnt_reg;
    logic [31:0]     cnt_next;
`ifdef WRONG_WAY_EN
    logic [1:0]      ww_all;
`endif

    // -------------------------------------------------------------------------
    // Per-player sector pipeline and progress tracking
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            sector_t    sec_comb;
            sector_t    sec_q_reg;
            sector_t    prog_reg;
            sector_t    prog_next;
            logic [1:0] prog_plus;
            logic [2:0] lap_reg;
            logic [2:0] lap_next;
            logic       fin_next;

            assign sec_comb  = sector_of(pos_x[gi], pos_y[gi]);
            assign prog_plus = prog_reg + 2'd1;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sec_q_reg <= SEC_GRID;
                    prog_reg  <= SEC_GRID;
                    lap_reg   <= 3'd0;
                end else begin
                    sec_q_reg <= sec_comb;
                    prog_reg  <= prog_next;
                    lap_reg   <= lap_next;
                end
            end

            // Progress only moves forward by exactly one sector; skips,
            // reversals and standing still are ignored. A finished player
            // (nonzero order) is frozen.
            always_comb begin
                prog_next = prog_reg;
                lap_next  = lap_reg;
                fin_next  = 1'b0;
                if (clear) begin
                    prog_next = SEC_GRID;
                    lap_next  = 3'd0;
                end else if (racing && (order_reg[gi] == 2'd0) && (sec_q_reg == prog_plus)) begin
                    prog_next = sec_q_reg;
                    if (prog_reg == SEC_SE) begin
                        if (lap_reg < LAPS) begin
                            lap_next = lap_reg + 3'd1;
                        end
                        if (lap_reg == LAPS - 3'd1) begin
                            fin_next = 1'b1;
                        end
                    end
                end
            end

            assign fin_now[gi] = fin_next;
            assign lap_all[gi] = lap_reg;

`ifdef WRONG_WAY_EN
            logic [1:0] prog_minus;
            logic       ww_reg;
            logic       ww_next;

            assign prog_minus = prog_reg - 2'd1;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ww_reg <= 1'b0;
                end else begin
                    ww_reg <= ww_next;
                end
            end

            always_comb begin
                ww_next = ww_reg;
                if (clear) begin
                    ww_next = 1'b0;
                end else if (racing) begin
                    if (sec_q_reg == prog_minus) begin
                        ww_next = 1'b1;
                    end else if ((sec_q_reg == prog_reg) || (prog_next != prog_reg)) begin
                        ww_next = 1'b0;
                    end
                end
            end

            assign ww_all[gi] = ww_reg;
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Finish order, post-finish timeout and game end
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            order_reg <= '0;
            first_reg <= 1'b0;
            end_reg   <= 1'b0;
            cnt_reg   <= 32'd0;
        end else begin
            order_reg <= order_next;
            first_reg <= first_next;
            end_reg   <= end_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        order_next = order_reg;
        first_next = first_reg;
        end_next   = end_reg;
        cnt_next   = cnt_reg;
        if (clear) begin
            order_next = '0;
            first_next = 1'b0;
            end_next   = 1'b0;
            cnt_next   = 32'd0;
        end else begin
            if ((order_reg[0] != 2'd0) && (order_reg[1] != 2'd0)) begin
                end_next = 1'b1;
            end
            if (racing) begin
                // Timeout runs from the edge after the first finisher is
                // registered; PAUSE/FINISH freeze it.
                if (first_reg && !end_reg) begin
                    if (cnt_reg == LAST_TICK) begin
                        end_next = 1'b1;
                        for (int p = 0; p < 2; p++) begin
                            if (order_reg[p] == 2'd0) begin
                                order_next[p] = 2'd2;
                            end
                        end
                    end else begin
                        cnt_next = cnt_reg + 32'd1;
                    end
                end
                // Same-cycle finish: P1 takes first place.
                if (fin_now[0]) begin
                    order_next[0] = first_reg ? 2'd2 : 2'd1;
                end
                if (fin_now[1]) begin
                    order_next[1] = (first_reg || fin_now[0]) ? 2'd2 : 2'd1;
                end
                if (fin_now != 2'b00) begin
                    first_next = 1'b1;
                end
            end
        end
    end

    assign p1_lap      = lap_all[0];
    assign p2_lap      = lap_all[1];
    assign p1_order    = order_reg[0];
    assign p2_order    = order_reg[1];
    assign is_game_end = end_reg;
`ifdef WRONG_WAY_EN
    assign p1_wrong_way = ww_all[0];
    assign p2_wrong_way = ww_all[1];
`endif

endmodule

// File: doc/race_progress_tracker.md
Name: race_progress_tracker

Overview:
- Lap/checkpoint referee that sits directly upstream of the top-level game FSM (StateEncoder) and the HUD flag renderer.
- Consumes both players' world positions from the physics engines and the game state.
- Produces per-player lap counts and finish order (p1_order/p2_order, 2-bit, same encoding the flag renderer indexes).
- Produces is_game_end, which feeds StateEncoder's is_game_end input (currently tied to 0).

Parameters:
- NUM_LAPS, 3, laps needed to finish; legal 1..7.
- CX, 160, sector split X in world pixels (map is 320x240).
- CY, 120, sector split Y in world pixels.
- FINISH_TIMEOUT, 32'd1_000_000_000, clk cycles (10 s at 100 MHz) after the first finisher before the race is forced to end.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low.
- state  in  3  game state; RACING=3'd4, PAUSE=3'd5, FINISH=3'd6, all others are "not racing".
- p1_x  in  10  P1 world X.
- p1_y  in  10  P1 world Y.
- p2_x  in  10  P2 world X.
- p2_y  in  10  P2 world Y.
- p1_lap  out  3  completed laps of P1, saturates at NUM_LAPS.
- p2_lap  out  3  completed laps of P2, saturates at NUM_LAPS.
- p1_order  out  2  0=still racing, 1=first, 2=second.
- p2_order  out  2  same encoding for P2.
- is_game_end  out  1  level; high until the next clear.

Behaviour:
- Reset (rst=0, async): all outputs 0; progress registers 0; sector registers 0; timeout counter 0; first-place-taken flag 0.
- Sector map, combinational per player:
  - S0: x<CX, y>=CY (start grid).
  - S1: x<CX, y<CY.
  - S2: x>=CX, y<CY.
  - S3: x>=CX, y>=CY.
  - Comparisons are unsigned 10-bit.
- Stage 1: sector registered every clk edge (sec_q), regardless of state.
- Stage 2: per-player progress FSM, 2-bit prog = last correctly reached sector. Updates only when state==RACING and the player is not finished.
  - If sec_q == prog+1 (mod 4), prog <= sec_q.
  - Any other sector (backward, diagonal skip, same) leaves prog unchanged.
  - A prog transition 3->0 increments lap. Saturating; never exceeds NUM_LAPS.
- Latency: a position change at edge N is in sec_q after N, and lap/order change after N+1 (2 cycles). All outputs are registered.
- Finish: on the cycle lap reaches NUM_LAPS, the player is finished and order is assigned:
  - 1 if first place is still free, else 2.
  - Simultaneous finish in the same cycle: P1 gets 1, P2 gets 2.
  - Order and lap freeze after finishing.
- Timeout: counter starts on the cycle the first order becomes nonzero and counts only while state==RACING (frozen in PAUSE).
  - When the count reaches FINISH_TIMEOUT-1, is_game_end <= 1.
  - The unfinished player gets order 2 and keeps its lap count.
- is_game_end also asserts one cycle after both players are finished. It stays high while state==RACING, PAUSE or FINISH.
- State handling:
  - PAUSE: everything holds; sec_q still tracks.
  - Any state other than RACING/PAUSE/FINISH performs a synchronous clear of prog, lap, order, counter and is_game_end to reset values. IDLE/SETTING/COUNTDOWN therefore start each race clean.
  - FINISH: holds all values for HUD display.
- Position inputs are assumed quasi-static relative to clk. No extra synchronisation; they come from the same clock domain.

Optional Feature:
- Macro WRONG_WAY_EN.
- When defined, adds outputs p1_wrong_way and p2_wrong_way (1 bit each, reset 0).
  - Set on the cycle, while RACING, that sec_q == prog-1 (mod 4).
  - Cleared when sec_q returns to prog or prog advances, or on the synchronous clear.
  - Held during PAUSE.
- When undefined, the ports and logic are absent; everything else is identical.

Test Plan:
- Reset: rst low mid-race with p1_lap=2 -> all outputs 0 immediately (async), prog=0 after release.
- Clean lap: state=4, P1 walks S0->S1->S2->S3->S0 (e.g. (20,125)->(20,60)->(200,60)->(200,180)->(20,125)) -> p1_lap=1 two cycles after re-entering S0; p2_lap stays 0.
- Cheating: P1 goes S0->S2->S3->S0 (skips S1) and S0->S3->S0 (backward) -> p1_lap stays 0.
- Finish and tie: NUM_LAPS=1, both players enter S0 from S3 on the same cycle -> p1_order=1, p2_order=2, is_game_end=1 one cycle later.
- Timeout and pause: FINISH_TIMEOUT=100, P2 finishes, state=PAUSE for 50 cycles mid-count, then RACING -> is_game_end rises exactly 100 RACING cycles after p2_order=1; p1_order=2.
- Clear: after game end, state=0 for one cycle -> laps, orders and is_game_end all 0 next cycle; with WRONG_WAY_EN, P1 S1->S0 backward raises p1_wrong_way, and it drops when S1 is re-entered.
